// File: rtl/int_priority_encoder_pkg.sv
// int_priority_encoder_pkg: shared sizes, FSM state type and lowest-index helper
package int_priority_encoder_pkg;
  localparam int N_DEF = 4;
  localparam int NUM_LINES = 2**N_DEF;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  function automatic logic [N_DEF-1:0] lowest_set_index(input logic [NUM_LINES-1:0] v);
    lowest_set_index = '0;
    for (int i = NUM_LINES-1; i >= 0; i--) if (v[i]) lowest_set_index = N_DEF'(i);
  endfunction
endpackage

// File: rtl/int_priority_encoder_prio_enc_comb.sv
// prio_enc_comb: combinational lowest-index encoder of a 2**N vector
module prio_enc_comb #(
  parameter int N = 4
) (
  input  logic [2**N-1:0] vec,
  output logic [N-1:0]    code,
  output logic            any
);
  // scanning downward lets the lowest set index overwrite last
  always_comb begin
    code = '0;
    for (int i = 2**N-1; i >= 0; i--) if (vec[i]) code = N'(i);
    any = |vec;
  end
endmodule

// File: rtl/int_priority_encoder.sv
// int_priority_encoder: edge-latched requests presented as a registered code with valid/ack
module int_priority_encoder
  import int_priority_encoder_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2**N-1:0] irq_lines,
  input  logic [2**N-1:0] irq_mask,
  output logic            int_valid,
  output logic [N-1:0]    int_code,
  input  logic            int_ack,
  output logic            int_lost,
  output logic [2**N-1:0] pending
);
  localparam int L = 2**N;
  logic [L-1:0] prev, edge_v, clr, cand;
  logic [N-1:0] code;
  logic any;
  state_t state, state_d;
  prio_enc_comb #(.N(N)) u_enc (.vec(cand), .code(code), .any(any));
  // edge detect, ack-driven clear and next-state selection
  always_comb begin
    edge_v = irq_lines & ~prev;
    clr = (int_valid && int_ack) ? (L'(1) << int_code) : '0;
    cand = pending & irq_mask;
    state_d = state;
    if (state == IDLE && any) state_d = HOLD;
    else if (state == HOLD && int_ack) state_d = IDLE;
  end
  // state, pending and output registers; prev resets high so a level-high line is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev <= '1;
      pending <= '0;
      int_valid <= 1'b0;
      int_code <= '0;
      int_lost <= 1'b0;
    end else begin
      state <= state_d;
      prev <= irq_lines;
      pending <= edge_v | (pending & ~clr);
      int_lost <= |(edge_v & pending & ~clr);
      int_valid <= state_d == HOLD;
      int_code <= (state == IDLE && any) ? code : int_code;
    end
  end
endmodule

// File: tb/tb_int_priority_encoder.sv
// tb_int_priority_encoder: directed checks of latching, priority, hold, mask, lost and reset
module tb_int_priority_encoder;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] irq_lines, irq_mask, pending;
  logic int_valid, int_ack, int_lost;
  logic [3:0] int_code;
  int n_chk = 0;
  int n_fail = 0;

  int_priority_encoder #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .irq_lines(irq_lines), .irq_mask(irq_mask),
    .int_valid(int_valid), .int_code(int_code), .int_ack(int_ack),
    .int_lost(int_lost), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    irq_lines = '0;
    irq_mask = 16'hFFFF;
    int_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int_valid, 0);
    check("rst_code", int_code, 0);
    check("rst_lost", int_lost, 0);
    check("rst_pending", pending, 0);
    rst_n = 1'b1;
    tick(); tick();
    irq_lines = 16'h0020; tick();
    check("t1_pending", pending, 16'h0020);
    check("t1_valid_early", int_valid, 0);
    irq_lines = '0; tick();
    check("t1_valid", int_valid, 1);
    check("t1_code", int_code, 5);
    int_ack = 1'b1; tick();
    check("t1_ack_valid", int_valid, 0);
    check("t1_ack_pending", pending, 0);
    int_ack = 1'b0;
    irq_lines = 16'h0208; tick();
    check("t2_pending", pending, 16'h0208);
    irq_lines = '0; tick();
    check("t2_code3", int_code, 3);
    check("t2_valid3", int_valid, 1);
    int_ack = 1'b1; tick();
    check("t2_gap", int_valid, 0);
    check("t2_pending9", pending, 16'h0200);
    int_ack = 1'b0; tick();
    check("t2_valid9", int_valid, 1);
    check("t2_code9", int_code, 9);
    int_ack = 1'b1; tick();
    check("t2_pending0", pending, 0);
    int_ack = 1'b0;
    irq_lines = 16'h0080; tick();
    irq_lines = '0; tick();
    check("t3_code7", int_code, 7);
    irq_lines = 16'h0001; tick();
    check("t3_pending", pending, 16'h0081);
    check("t3_hold_code", int_code, 7);
    irq_lines = '0; tick();
    check("t3_hold_code2", int_code, 7);
    check("t3_hold_valid", int_valid, 1);
    int_ack = 1'b1; tick();
    check("t3_ack_pending", pending, 16'h0001);
    int_ack = 1'b0; tick();
    check("t3_code0", int_code, 0);
    check("t3_valid0", int_valid, 1);
    int_ack = 1'b1; tick();
    check("t3_pending0", pending, 0);
    int_ack = 1'b0;
    irq_mask = 16'hFFFE;
    irq_lines = 16'h0001; tick();
    check("t4_pending", pending, 16'h0001);
    irq_lines = '0; tick();
    check("t4_masked_valid", int_valid, 0);
    int_ack = 1'b1; tick();
    check("t4_ack_ignored", pending, 16'h0001);
    check("t4_masked_valid2", int_valid, 0);
    int_ack = 1'b0;
    irq_mask = 16'hFFFF; tick();
    check("t4_unmask_valid", int_valid, 1);
    check("t4_unmask_code", int_code, 0);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    irq_lines = 16'h0004; tick();
    irq_lines = '0; tick();
    check("t5_code2", int_code, 2);
    int_ack = 1'b1;
    irq_lines = 16'h0004; tick();
    check("t5_setwins", pending, 16'h0004);
    check("t5_no_lost", int_lost, 0);
    check("t5_gap", int_valid, 0);
    int_ack = 1'b0;
    irq_lines = '0; tick();
    check("t5_re_valid", int_valid, 1);
    check("t5_re_code", int_code, 2);
    int_ack = 1'b1; tick();
    check("t5_pending0", pending, 0);
    int_ack = 1'b0;
    irq_lines = 16'h0010; tick();
    irq_lines = '0; tick();
    check("t5_code4", int_code, 4);
    check("t5_lost_pre", int_lost, 0);
    irq_lines = 16'h0010; tick();
    check("t5_lost", int_lost, 1);
    check("t5_pending4", pending, 16'h0010);
    irq_lines = '0; tick();
    check("t5_lost_pulse", int_lost, 0);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    irq_lines = 16'h0040; tick();
    irq_lines = '0; tick();
    check("t6_valid", int_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", int_valid, 0);
    check("t6_async_pending", pending, 0);
    irq_lines = 16'hFFFF;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_level_pending", pending, 0);
    check("t6_level_valid", int_valid, 0);
    check("t6_level_lost", int_lost, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
